rob_ar_scheduler: RTL
=====================

// Module: rob_ar_scheduler
// PURPOSE
// - Shares the reorder buffer's AR slave port between NUM_REQ read requesters.
// - Round-robin arbitration; allocates a unique 4-bit AXI ID per transaction from a 16-entry free pool.
// - Frees each ID when the reorder buffer delivers that ID's R beat.
// - Reports the owning requester of every returned beat so responses can be routed back.
// PARAMETERS
// - NUM_REQ          4   number of requesters, 2..8
// - MAX_OUTSTANDING  16  cap on allocated IDs, 1..16
// - OWN_W  $clog2(NUM_REQ)  localparam, owner index width
// PORTS
// - clk              in   1        clock; all state on posedge
// - rst              in   1        async reset, active-high
// - req_valid_i      in   NUM_REQ  per-requester read request; held until matching req_ready_o
// - req_ready_o      out  NUM_REQ  one-hot accept pulse, one cycle
// - m_arid_o         out  4        allocated ID to ROB AR slave
// - m_arvalid_o      out  1        AR valid to ROB
// - m_arready_i      in   1        AR ready from ROB
// - r_done_i         in   1        ROB R handshake (s_rvalid && s_rready)
// - r_done_id_i      in   4        ID of that R beat
// - r_owner_o        out  OWN_W    comb: owner[r_done_id_i]
// - outstanding_o    out  5        IDs currently allocated
// - err_o            out  1        sticky: free of an unallocated ID
// BEHAVIOUR
// Reset (async, rst=1)
// - state=IDLE; m_arvalid_o=0; m_arid_o=0; req_ready_o=0.
// - free_mask=16'hFFFF; outstanding_o=0; rr_ptr=0; err_o=0.
// - Owner table cleared to 0. Any in-flight AR is dropped immediately.
// FSM: IDLE, ISSUE
// - IDLE -> ISSUE when all of the following hold in the same cycle:
//   - any req_valid_i;
//   - outstanding_o < MAX_OUTSTANDING;
//   - free_mask != 0.
// - On that transition:
//   - Winner = first set req_valid_i at or after rr_ptr, wrapping.
//   - ID = lowest set bit of the registered free_mask.
//   - Register grant/ID, clear the free_mask bit, owner[ID] <= winner, outstanding += 1.
// - ISSUE:
//   - m_arvalid_o=1; m_arid_o stable until the handshake.
//   - req_ready_o[winner] = m_arready_i (comb).
//   - On m_arvalid_o && m_arready_i -> IDLE; rr_ptr <= winner+1 mod NUM_REQ.
// - Throughput: max one AR per 2 cycles. First m_arvalid_o rises one cycle after req_valid_i.
// Free path (any state)
// - r_done_i && !free_mask[r_done_id_i]: set bit, outstanding -= 1.
// - r_done_i on an already-free ID: no state change, err_o <= 1 (cleared only by rst).
// - Same-cycle alloc and free: outstanding_o unchanged. The freed ID is allocatable from the next cycle only, since allocation reads the registered mask.
// Boundaries
// - Pool empty or at cap: stay IDLE; req_ready_o=0; requests wait.
// - Free in that cycle: allocation is possible the following cycle.
// - rr_ptr wraps NUM_REQ-1 -> 0.
// - outstanding_o never exceeds MAX_OUTSTANDING and never underflows.
// - req_valid_i dropping mid-ISSUE is a protocol violation. AR still completes; the ID stays allocated.
// CONFIGURATION
// - ROB_SCHED_CFG_LIMIT_EN defined: adds port cfg_max_out_i in 5.
//   - Effective cap = min(cfg_max_out_i, MAX_OUTSTANDING); cfg_max_out_i=0 blocks all new grants.
//   - Lowering the cap below outstanding_o leaves existing IDs valid. No grant until outstanding_o < cap.
// - Undefined: port absent; cap = MAX_OUTSTANDING.
// TESTING
// - Reset release, no requests -> m_arvalid_o=0, outstanding_o=0, free_mask=FFFF, err_o=0 for 10 cycles.
// - req_valid_i=4'b1111 held, m_arready_i=1 -> grants 0,1,2,3,0 with IDs 0,1,2,3,4; one AR every 2 cycles.
// - 16 grants, no frees -> 17th request stalls, outstanding_o=16; r_done_i id=5 -> next grant uses ID 5.
// - m_arready_i=0 for 5 cycles in ISSUE -> m_arvalid_o and m_arid_o stable, req_ready_o=0; ready=1 -> one-cycle req_ready_o.
// - Alloc ID 2 (owner 3) then r_done_i id=2 -> r_owner_o=3, outstanding_o-1; r_done_i id=9 unallocated -> err_o=1, sticky.
// - rst=1 mid-ISSUE -> m_arvalid_o=0 same cycle; all state reset. CFG_LIMIT_EN with cfg_max_out_i=2 -> third grant blocked until a free.

Source files
------------

// File: rtl/rob_ar_scheduler.sv
// Round-robin AR scheduler for the reorder buffer: allocates 4-bit AXI IDs from a
// free pool, tracks owners, frees IDs on R beats. Optional cap port: ROB_SCHED_CFG_LIMIT_EN.
//
// state | meaning
// IDLE  | no AR pending; grant and allocate when a request, a free ID and headroom exist
// ISSUE | AR presented to the ROB with a stable ID until m_arready_i
module rob_ar_scheduler #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 16,
    localparam int OWN_W          = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid_i,
    output logic [NUM_REQ-1:0] req_ready_o,
    output logic [3:0]         m_arid_o,
    output logic               m_arvalid_o,
    input  logic               m_arready_i,
    input  logic               r_done_i,
    input  logic [3:0]         r_done_id_i,
    output logic [OWN_W-1:0]   r_owner_o,
    output logic [4:0]         outstanding_o,
`ifdef ROB_SCHED_CFG_LIMIT_EN
    input  logic [4:0]         cfg_max_out_i,
`endif
    output logic               err_o
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;
    localparam logic [4:0] MAX_OUT = 5'(MAX_OUTSTANDING);

    logic [0:0]       state;
    logic [OWN_W-1:0] grant_idx;
    logic [OWN_W-1:0] rr_ptr;
    logic [15:0]      free_mask;
    logic [OWN_W-1:0] owner [16];

    logic [4:0]       eff_cap;
    logic             alloc;
    logic             free_hit;
    logic             ar_hs;
    logic [3:0]       alloc_id;
    logic [OWN_W-1:0] win_idx;
    logic [OWN_W-1:0] hi_idx;
    logic [OWN_W-1:0] lo_idx;
    logic             hi_found;

`ifdef ROB_SCHED_CFG_LIMIT_EN
    assign eff_cap = (cfg_max_out_i < MAX_OUT) ? cfg_max_out_i : MAX_OUT;
`else
    assign eff_cap = MAX_OUT;
`endif

    // Two-pass priority: requesters at/after rr_ptr beat those that wrapped.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_valid_i[j]) begin
                if (OWN_W'(j) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = OWN_W'(j);
                end else begin
                    lo_idx = OWN_W'(j);
                end
            end
        end
        win_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        alloc_id = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (free_mask[k]) alloc_id = 4'(k);
        end
    end

    assign alloc    = (state == IDLE) && (|req_valid_i) && (outstanding_o < eff_cap)
                      && (free_mask != 16'h0000);
    assign free_hit = r_done_i && !free_mask[r_done_id_i];
    assign ar_hs    = (state == ISSUE) && m_arready_i;

    assign m_arvalid_o = (state == ISSUE);
    assign r_owner_o   = owner[r_done_id_i];

    always_comb begin
        req_ready_o = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            req_ready_o[j] = ar_hs && (grant_idx == OWN_W'(j));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            grant_idx     <= '0;
            m_arid_o      <= 4'd0;
            rr_ptr        <= '0;
            free_mask     <= 16'hFFFF;
            outstanding_o <= 5'd0;
            err_o         <= 1'b0;
            for (int i = 0; i < 16; i++) owner[i] <= '0;
        end else begin
            if (alloc) begin
                state            <= ISSUE;
                grant_idx        <= win_idx;
                m_arid_o         <= alloc_id;
                owner[alloc_id]  <= win_idx;
            end else if (ar_hs) begin
                state  <= IDLE;
                rr_ptr <= (grant_idx == OWN_W'(NUM_REQ - 1)) ? '0 : grant_idx + OWN_W'(1);
            end

            // An allocated ID always has its mask bit clear, so alloc and free never collide.
            free_mask <= (free_mask & ~({15'd0, alloc} << alloc_id))
                         | ({15'd0, free_hit} << r_done_id_i);
            outstanding_o <= outstanding_o + {4'd0, alloc} - {4'd0, free_hit};

            if (r_done_i && free_mask[r_done_id_i]) err_o <= 1'b1;
        end
    end

endmodule
